// File: rtl/regfile_bypass_sb.sv
// Decode-stage register file: two combinational read ports with write-first bypass,
// per-register pending-write scoreboard, and a post-reset sweep that zeroes storage.
module regfile_bypass_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_pend_a,
  output logic              rd_pend_b,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   sweep_reg, sweep_next;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    pend_vec;
  logic                run;
  logic                wr_fire;
  logic                claim_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= CLEAR;
      sweep_reg <= '0;
    end else begin
      state_reg <= state_next;
      sweep_reg <= sweep_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sweep_next = sweep_reg;
    case (state_reg)
      CLEAR: begin
        sweep_next = sweep_reg + 1'b1;
        if (sweep_reg == LAST_ADDR) state_next = RUN;
      end
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  assign run   = (state_reg == RUN);
  assign ready = run;

  // Register 0 is hardwired when ZERO_REG is set, so its writes and claims never land.
  assign wr_fire    = run && wr_en    && !(ZERO_REG && (wr_addr == '0));
  assign claim_fire = run && claim_en && !(ZERO_REG && (claim_addr == '0));

  always_ff @(posedge clk) begin
    if (!run) begin
      mem[sweep_reg] <= '0;
    end else if (wr_fire && !reset) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A claim outranks a retiring write to the same register: the younger producer still owes data.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_pend
      logic pend_bit_reg;
      always_ff @(posedge clk) begin
        if (reset || !run) begin
          pend_bit_reg <= 1'b0;
        end else if (claim_fire && (claim_addr == ADDR_W'(gi))) begin
          pend_bit_reg <= 1'b1;
        end else if (wr_fire && (wr_addr == ADDR_W'(gi))) begin
          pend_bit_reg <= 1'b0;
        end
      end
      assign pend_vec[gi] = pend_bit_reg;
    end
  endgenerate

  logic [ADDR_W-1:0] port_addr [2];
  logic [DATA_W-1:0] port_data [2];
  logic              port_pend [2];

  assign port_addr[0] = rd_addr_a;
  assign port_addr[1] = rd_addr_b;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      always_comb begin
        port_data[gi] = '0;
        port_pend[gi] = 1'b0;
        if (run) begin
          if (ZERO_REG && (port_addr[gi] == '0)) begin
            port_data[gi] = '0;
          end else if (wr_en && (wr_addr == port_addr[gi])) begin
            port_data[gi] = wr_data;
          end else begin
            port_data[gi] = mem[port_addr[gi]];
            port_pend[gi] = pend_vec[port_addr[gi]];
          end
        end
      end
    end
  endgenerate

  assign rd_data_a = port_data[0];
  assign rd_data_b = port_data[1];
  assign rd_pend_a = port_pend[0];
  assign rd_pend_b = port_pend[1];

endmodule

// File: doc/regfile_bypass_sb.md
# regfile_bypass_sb

Parametrised register file for the MIPS datapath, replacing the fixed 32x32 two-read/one-write file. It adds write-to-read bypass, a per-register pending-write scoreboard for pipeline hazard detection, and a post-reset clearing sweep that zeroes every register. It sits in the decode stage: the read ports feed operand muxes, the claim port is driven at issue, and the write port is driven from writeback.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes and claims
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- wr_en  in  1  writeback write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- claim_en  in  1  issue-stage claim: mark destination register pending
- claim_addr  in  ADDR_W  register to mark pending
- rd_addr_a / rd_addr_b  in  ADDR_W  read addresses
- rd_data_a / rd_data_b  out  DATA_W  read data (combinational)
- rd_pend_a / rd_pend_b  out  1  read register has an outstanding claim, data not yet valid
- ready  out  1  block out of clearing sweep, ports live

## Operation
- States: CLEAR, RUN. reset=1 forces CLEAR with sweep counter=0 and all pending bits cleared, every cycle reset is high; reset mid-sweep or mid-RUN restarts the sweep.
- CLEAR, reset low: each cycle writes 0 to register[counter] and increments the counter. After writing register DEPTH-1, the next state is RUN. The sweep lasts DEPTH cycles after reset deasserts.
- In CLEAR: ready=0, rd_data_*=0, rd_pend_*=0, wr_en and claim_en ignored.
- In RUN: ready=1.
  - Write: wr_en stores wr_data at wr_addr and clears pending[wr_addr].
  - Claim: claim_en sets pending[claim_addr].
  - Same address, same cycle: the claim wins, so pending stays 1 (a younger producer issued while an older one retires). The data is still written.
- Read data priority per port:
  1. ZERO_REG=1 and addr=0: 0.
  2. wr_en and wr_addr==addr (write-first bypass): wr_data.
  3. Otherwise: stored value.
- rd_pend_x = pending[addr], forced to 0 when ZERO_REG=1 and addr=0, or when a same-cycle write to addr bypasses. A same-cycle claim does not affect rd_pend in that cycle.
- ZERO_REG=1: writes and claims to address 0 are dropped, and pending[0] is never set.
- ZERO_REG=0: register 0 behaves like any other register.
- Both read ports may address the same register. Each port resolves independently with identical results.
- Writes to a register with no claim are legal. They store data, and pending stays 0.

## Timing
- Reads are combinational, with zero latency from rd_addr/wr_* to rd_data/rd_pend.
- Write is visible by bypass in the same cycle and from storage starting the next cycle.
- Claim is visible on rd_pend starting the cycle after claim_en.
- ready rises DEPTH cycles after the first rising edge with reset low; for ADDR_W=5 that is cycle 32.
- Reset values: ready=0, rd_data_a/b=0, rd_pend_a/b=0, all pending bits 0, all registers 0 once the sweep completes.

## Test plan
- Reset sweep: pre-load reg 7=0xDEADBEEF, assert reset 1 cycle, release. Required: ready=0 for 32 cycles, then 1; reading reg 7 returns 0. Assert reset again at sweep cycle 10: ready stays 0 for a further full 32 cycles.
- Bypass: in RUN, write reg 5=0x12345678 with rd_addr_a=rd_addr_b=5 in the same cycle. Required: both rd_data=0x12345678 that cycle and afterwards. Write reg 0=0xFFFFFFFF: reads of reg 0 return 0.
- Scoreboard: claim reg 9 at cycle t. Required: rd_pend=1 from t+1. Write reg 9=0xA5 at t+3: rd_pend=0 and rd_data=0xA5 in cycle t+3 via bypass, and pend stays 0 after.
- Simultaneous claim and write to reg 12 with data 0x3C. Required: next cycle rd_data=0x3C and rd_pend=1.
- Claim during CLEAR on reg 4, then write during CLEAR. Required: both ignored; after ready, reg 4 reads 0 with pend 0.
- ZERO_REG=0, ADDR_W=3 build: write reg 0=0x77. Required: reads 0x77; sweep lasts 8 cycles.
